// File: rtl/ysyx_25040129_scoreboard.sv
// Register/CSR write-pending scoreboard between IDU issue and WBU retire.
// Optional CSR tracking is built when YSYX_25040129_SB_CSR_EN is defined.
module ysyx_25040129_scoreboard #(
   parameter int CNT_W      = 2,
   parameter int INFLIGHT_W = 2,
   parameter int REGS_DIG   = 4,
   parameter int CSR_DIG    = 3
) (
   input  logic                  clk,
   input  logic                  rst_n,
   input  logic                  issue_fire,
   input  logic [REGS_DIG-1:0]   issue_rd,
   input  logic                  issue_rd_we,
   input  logic [CSR_DIG-1:0]    issue_csr,
   input  logic                  issue_csr_we,
   input  logic                  retire_fire,
   input  logic [REGS_DIG-1:0]   retire_rd,
   input  logic                  retire_rd_we,
   input  logic [CSR_DIG-1:0]    retire_csr,
   input  logic                  retire_csr_we,
   input  logic [REGS_DIG-1:0]   src1_id,
   input  logic [REGS_DIG-1:0]   src2_id,
   input  logic                  src1_used,
   input  logic                  src2_used,
   input  logic [CSR_DIG-1:0]    csr_rd_id,
   input  logic                  csr_used,
   input  logic                  flush,
   output logic                  raw_stall,
   output logic [INFLIGHT_W-1:0] inflight_cnt,
   output logic                  sb_empty,
   output logic                  sb_err
);

   // issue_fire / retire_fire mark handshakes already completed this cycle
   // (valid & ready on the IDU->EXU and WBU commit sides); no backpressure here.
   localparam int NREG = 1 << REGS_DIG;
   localparam logic [CNT_W-1:0]      CNT_MAX = '1;
   localparam logic [INFLIGHT_W-1:0] INF_MAX = '1;

   // Entry 0 is never written, so x0 always reads as not pending.
   logic [CNT_W-1:0]      rd_cnt [NREG];
   logic [INFLIGHT_W-1:0] inflight_q;
   logic                  err_q;

   logic live;
   logic rd_inc, rd_dec, rd_hold, rd_err;
   logic inf_inc, inf_dec, inf_err;
   logic csr_stall, csr_err;

   assign live = ~flush;

   always_comb begin
      rd_inc  = live & issue_fire & issue_rd_we & (issue_rd != '0);
      rd_dec  = live & retire_fire & retire_rd_we & (retire_rd != '0);
      rd_hold = rd_inc & rd_dec & (issue_rd == retire_rd);
      rd_err  = (rd_inc & ~rd_hold & (rd_cnt[issue_rd] == CNT_MAX)) |
                (rd_dec & ~rd_hold & (rd_cnt[retire_rd] == '0));
      inf_inc = live & issue_fire;
      inf_dec = live & retire_fire;
      inf_err = (inf_inc & ~inf_dec & (inflight_q == INF_MAX)) |
                (inf_dec & ~inf_inc & (inflight_q == '0));
   end

   always_ff @(posedge clk) begin
      if (!rst_n) begin
         for (int i = 0; i < NREG; i++) rd_cnt[i] <= '0;
         inflight_q <= '0;
         err_q      <= 1'b0;
      end else begin
         err_q <= err_q | rd_err | inf_err | csr_err;
         if (flush) begin
            for (int i = 0; i < NREG; i++) rd_cnt[i] <= '0;
            inflight_q <= '0;
         end else begin
            for (int i = 1; i < NREG; i++) begin
               if (rd_inc && !rd_hold && issue_rd == REGS_DIG'(i) && rd_cnt[i] != CNT_MAX)
                  rd_cnt[i] <= rd_cnt[i] + CNT_W'(1);
               else if (rd_dec && !rd_hold && retire_rd == REGS_DIG'(i) && rd_cnt[i] != '0)
                  rd_cnt[i] <= rd_cnt[i] - CNT_W'(1);
            end
            if (inf_inc && !inf_dec && inflight_q != INF_MAX)
               inflight_q <= inflight_q + INFLIGHT_W'(1);
            else if (inf_dec && !inf_inc && inflight_q != '0)
               inflight_q <= inflight_q - INFLIGHT_W'(1);
         end
      end
   end

`ifdef YSYX_25040129_SB_CSR_EN
   localparam int NCSR = 1 << CSR_DIG;
   logic [CNT_W-1:0] csr_cnt [NCSR];
   logic csr_inc, csr_dec, csr_hold;

   // CSR id 0 is an ordinary CSR, so every entry is tracked.
   always_comb begin
      csr_inc   = live & issue_fire & issue_csr_we;
      csr_dec   = live & retire_fire & retire_csr_we;
      csr_hold  = csr_inc & csr_dec & (issue_csr == retire_csr);
      csr_err   = (csr_inc & ~csr_hold & (csr_cnt[issue_csr] == CNT_MAX)) |
                  (csr_dec & ~csr_hold & (csr_cnt[retire_csr] == '0));
      csr_stall = csr_used & (csr_cnt[csr_rd_id] != '0);
   end

   always_ff @(posedge clk) begin
      if (!rst_n || flush) begin
         for (int i = 0; i < NCSR; i++) csr_cnt[i] <= '0;
      end else begin
         for (int i = 0; i < NCSR; i++) begin
            if (csr_inc && !csr_hold && issue_csr == CSR_DIG'(i) && csr_cnt[i] != CNT_MAX)
               csr_cnt[i] <= csr_cnt[i] + CNT_W'(1);
            else if (csr_dec && !csr_hold && retire_csr == CSR_DIG'(i) && csr_cnt[i] != '0)
               csr_cnt[i] <= csr_cnt[i] - CNT_W'(1);
         end
      end
   end
`else
   logic csr_unused;
   assign csr_unused = ^{issue_csr, issue_csr_we, retire_csr, retire_csr_we, csr_rd_id, csr_used};
   assign csr_stall  = 1'b0;
   assign csr_err    = 1'b0;
`endif

   // Stall looks only at registered counters: a retiring writer frees its reader next cycle.
   assign raw_stall = (src1_used & (src1_id != '0) & (rd_cnt[src1_id] != '0)) |
                      (src2_used & (src2_id != '0) & (rd_cnt[src2_id] != '0)) |
                      (inflight_q == INF_MAX) | csr_stall;

   assign inflight_cnt = inflight_q;
   assign sb_empty     = (inflight_q == '0);
   assign sb_err       = err_q;

endmodule

// File: doc/ysyx_25040129_scoreboard.md
YSYX_25040129_SCOREBOARD -- requirements
Module: ysyx_25040129_scoreboard

Interface
REQ-001 SHALL have parameter CNT_W, default 2, width of each per-register pending counter (max in-flight writers per register = 2^CNT_W-1).
REQ-002 SHALL have parameter INFLIGHT_W, default 2, width of the total in-flight instruction counter.
REQ-003 SHALL have one clock and a synchronous, active-low reset.
REQ-004 SHALL have port clk  in  1  clock; all state updates on rising edge.
REQ-005 SHALL have port rst_n  in  1  synchronous active-low reset.
REQ-006 SHALL have port issue_fire  in  1  IDU->EXU handshake completed this cycle.
REQ-007 SHALL have port issue_rd  in  ysyx_25040129_REGS_DIG  destination register of issuing instruction.
REQ-008 SHALL have port issue_rd_we  in  1  issuing instruction writes issue_rd.
REQ-009 SHALL have port issue_csr  in  ysyx_25040129_CSR_DIG  CSR written by issuing instruction.
REQ-010 SHALL have port issue_csr_we  in  1  issuing instruction writes issue_csr.
REQ-011 SHALL have ports retire_fire / retire_rd / retire_rd_we / retire_csr / retire_csr_we  in  1/REGS_DIG/1/CSR_DIG/1  WBU commit, same meanings as issue ports.
REQ-012 SHALL have ports src1_id, src2_id  in  REGS_DIG  source registers of instruction in IDU.
REQ-013 SHALL have ports src1_used, src2_used  in  1  source actually read from register file.
REQ-014 SHALL have ports csr_rd_id  in  CSR_DIG and csr_used  in  1  CSR read by instruction in IDU.
REQ-015 SHALL have port flush  in  1  redirect; kills every in-flight instruction.
REQ-016 SHALL have port raw_stall  out  1  IDU must not issue (pending writer on a used source/CSR, or counter full).
REQ-017 SHALL have port inflight_cnt  out  INFLIGHT_W  instructions issued and not yet retired.
REQ-018 SHALL have port sb_empty  out  1  inflight_cnt==0.
REQ-019 SHALL have port sb_err  out  1  sticky: overflow, or retire with no matching pending entry.

Function
REQ-020 SHALL keep one CNT_W pending counter per architectural register 1..2^REGS_DIG-1; x0 SHALL never be tracked or cause a stall.
REQ-021 On issue_fire&issue_rd_we&issue_rd!=0, counter[issue_rd] SHALL increment at next edge.
REQ-022 On retire_fire&retire_rd_we&retire_rd!=0, counter[retire_rd] SHALL decrement at next edge.
REQ-023 Simultaneous increment and decrement of the same counter SHALL leave it unchanged.
REQ-024 inflight_cnt SHALL increment on issue_fire, decrement on retire_fire, unchanged when both.
REQ-025 raw_stall SHALL be combinational from registered state and query inputs only: asserted when (src1_used & src1_id!=0 & counter[src1_id]!=0) or same for src2, or CSR pending (REQ-034), or counter[issue_rd-candidate=src of IDU rd not available] — specifically when inflight_cnt is all-ones.
REQ-026 raw_stall SHALL NOT depend on same-cycle issue_fire or retire_fire (retiring writer unblocks the reader one cycle later).
REQ-027 Decrement of a zero counter, or retire_fire with inflight_cnt==0, SHALL leave state at zero and set sb_err.
REQ-028 Increment of a saturated counter or of inflight_cnt at all-ones SHALL saturate and set sb_err.
REQ-029 flush SHALL clear all counters and inflight_cnt at next edge; issue_fire and retire_fire in the flush cycle SHALL be ignored; sb_err SHALL be preserved.
REQ-030 sb_empty SHALL be registered-state derived, zero latency from inflight_cnt.

Reset
REQ-031 With rst_n==0 at a rising edge, all counters, inflight_cnt and sb_err SHALL become 0; raw_stall SHALL read 0 and sb_empty 1 the following cycle.
REQ-032 Reset SHALL take priority over flush, issue and retire in the same cycle, including mid-operation.

Configuration
REQ-033 Macro YSYX_25040129_SB_CSR_EN SHALL select CSR tracking.
REQ-034 Defined: one CNT_W counter per CSR id, updated per REQ-021..029 using *_csr/*_csr_we (id 0 tracked normally); raw_stall also asserted when csr_used & counter[csr_rd_id]!=0.
REQ-035 Undefined: no CSR counters synthesized; CSR ports present but ignored; CSR never contributes to raw_stall or sb_err.

Verification
REQ-036 Reset, then issue rd=5 we; query src1_id=5 used -> raw_stall=1 next cycle, inflight_cnt=1, sb_empty=0.
REQ-037 Issue rd=5 twice, retire rd=5 once -> raw_stall stays 1; second retire -> raw_stall 0 cycle after, sb_empty=1.
REQ-038 Same-cycle issue and retire of rd=7 with counter[7]=1 -> counter[7] stays 1, inflight_cnt unchanged.
REQ-039 Three issues (rd=1,2,3) then flush with concurrent retire rd=1 -> all counters 0, inflight_cnt=0, sb_err=0.
REQ-040 Retire rd=9 with counter[9]=0 -> sb_err=1 sticky until rst_n=0; issue rd=0 -> no stall on src1_id=0.
REQ-041 With YSYX_25040129_SB_CSR_EN: issue csr_we id=3, csr_used csr_rd_id=3 -> raw_stall=1; without macro -> raw_stall=0.
